// File: rtl/sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sram_ctrl_pkg
// Brief   : Shared types, port ids and parity helper for the SRAM port ctrl.
// Revision: 1.0
// ============================================================================
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        RUN    = 2'd1,
        RMW_WR = 2'd2
    } state_t;

    localparam int PORT_IF   = 0;
    localparam int PORT_DM   = 1;
    localparam int PAR_MAX_W = 64;

    // Narrower words are zero-extended by the caller, which leaves parity unchanged.
    function automatic logic parity(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : sram_rr_arbiter
// Brief   : Two-input round-robin arbiter; prio bit holds the favoured port id.
// Revision: 1.0
// ============================================================================
module sram_rr_arbiter
    import sram_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic r_prio;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (&valid) begin
                if (r_prio) grant[PORT_DM] = 1'b1;
                else        grant[PORT_IF] = 1'b1;
            end else begin
                grant = valid;
            end
        end
    end

    // Priority only rotates when both ports actually contended.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= 1'b1;
        end else if (enable && (&valid)) begin
            r_prio <= ~r_prio;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sram_port_ctrl
// Brief   : Fetch/data port controller for a 1rw SRAM with parity spare bit.
// Revision: 1.0
// ============================================================================
module sram_port_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 4,
    parameter int INIT_CLEAR = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_done,
    input  logic                  if_req_valid,
    output logic                  if_req_ready,
    input  logic [ADDR_WIDTH-1:0] if_req_addr,
    output logic                  if_rsp_valid,
    output logic [DATA_WIDTH-1:0] if_rsp_rdata,
    output logic                  if_rsp_perr,
    input  logic                  dm_req_valid,
    output logic                  dm_req_ready,
    input  logic                  dm_req_we,
    input  logic [NUM_WMASKS-1:0] dm_req_be,
    input  logic [ADDR_WIDTH-1:0] dm_req_addr,
    input  logic [DATA_WIDTH-1:0] dm_req_wdata,
    output logic                  dm_rsp_valid,
    output logic [DATA_WIDTH-1:0] dm_rsp_rdata,
    output logic                  dm_rsp_perr,
    output logic                  sram_csb,
    output logic                  sram_web,
    output logic [NUM_WMASKS-1:0] sram_wmask,
    output logic                  sram_spare_wen,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH:0]   sram_din,
    input  logic [DATA_WIDTH:0]   sram_dout
);

    localparam state_t RESET_STATE = state_t'((INIT_CLEAR != 0) ? INIT : RUN);

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_init_addr;
    logic                  r_if_rsp_valid;
    logic                  r_dm_rsp_valid;
    logic                  r_dm_rsp_rd;
    logic                  r_dm_rsp_perr;
    logic [ADDR_WIDTH-1:0] r_rmw_addr;
    logic [NUM_WMASKS-1:0] r_rmw_be;
    logic [DATA_WIDTH-1:0] r_rmw_wdata;
    logic [1:0]            w_grant;
    logic                  w_arb_en;
    logic                  w_rmw_start;
    logic                  w_dout_perr;
    logic [DATA_WIDTH-1:0] w_merged;

    assign w_arb_en    = !rst && (r_state == RUN);
    assign w_dout_perr = parity(PAR_MAX_W'(sram_dout));
    assign w_rmw_start = w_grant[PORT_DM] && dm_req_we
                         && (dm_req_be != '0) && !(&dm_req_be);

    sram_rr_arbiter u_arb (
        .clk    (clk),
        .rst    (rst),
        .enable (w_arb_en),
        .valid  ({dm_req_valid, if_req_valid}),
        .grant  (w_grant)
    );

    always_comb begin
        w_merged = sram_dout[DATA_WIDTH-1:0];
        for (int i = 0; i < NUM_WMASKS; i++) begin
            if (r_rmw_be[i]) w_merged[8*i +: 8] = r_rmw_wdata[8*i +: 8];
        end
    end

    // Macro issue is suppressed while rst is high so an in-flight RMW never commits.
    always_comb begin
        w_next_state   = r_state;
        sram_csb       = 1'b1;
        sram_web       = 1'b1;
        sram_wmask     = '0;
        sram_spare_wen = 1'b0;
        sram_addr      = '0;
        sram_din       = '0;
        if (!rst) begin
            case (r_state)
                INIT: begin
                    sram_csb       = 1'b0;
                    sram_web       = 1'b0;
                    sram_wmask     = '1;
                    sram_spare_wen = 1'b1;
                    sram_addr      = r_init_addr;
                    if (r_init_addr == '1) w_next_state = RUN;
                end
                RUN: begin
                    if (w_grant[PORT_IF]) begin
                        sram_csb  = 1'b0;
                        sram_addr = if_req_addr;
                    end else if (w_grant[PORT_DM]) begin
                        sram_addr = dm_req_addr;
                        if (!dm_req_we) begin
                            sram_csb = 1'b0;
                        end else if (&dm_req_be) begin
                            sram_csb       = 1'b0;
                            sram_web       = 1'b0;
                            sram_wmask     = '1;
                            sram_spare_wen = 1'b1;
                            sram_din       = {parity(PAR_MAX_W'(dm_req_wdata)), dm_req_wdata};
                        end else if (dm_req_be != '0) begin
                            sram_csb     = 1'b0;
                            w_next_state = RMW_WR;
                        end
                    end
                end
                RMW_WR: begin
                    sram_csb       = 1'b0;
                    sram_web       = 1'b0;
                    sram_wmask     = '1;
                    sram_spare_wen = 1'b1;
                    sram_addr      = r_rmw_addr;
                    sram_din       = {parity(PAR_MAX_W'(w_merged)), w_merged};
                    w_next_state   = RUN;
                end
                default: w_next_state = RESET_STATE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= RESET_STATE;
            r_init_addr    <= '0;
            r_if_rsp_valid <= 1'b0;
            r_dm_rsp_valid <= 1'b0;
            r_dm_rsp_rd    <= 1'b0;
            r_dm_rsp_perr  <= 1'b0;
            r_rmw_addr     <= '0;
            r_rmw_be       <= '0;
            r_rmw_wdata    <= '0;
        end else begin
            r_state        <= w_next_state;
            if (r_state == INIT) r_init_addr <= r_init_addr + ADDR_WIDTH'(1);
            r_if_rsp_valid <= w_grant[PORT_IF];
            r_dm_rsp_valid <= (w_grant[PORT_DM] && !w_rmw_start) || (r_state == RMW_WR);
            r_dm_rsp_rd    <= w_grant[PORT_DM] && !dm_req_we;
            r_dm_rsp_perr  <= (r_state == RMW_WR) && w_dout_perr;
            if (w_rmw_start) begin
                r_rmw_addr  <= dm_req_addr;
                r_rmw_be    <= dm_req_be;
                r_rmw_wdata <= dm_req_wdata;
            end
        end
    end

    assign init_done    = !rst && (r_state != INIT);
    assign if_req_ready = w_grant[PORT_IF];
    assign dm_req_ready = w_grant[PORT_DM];
    assign if_rsp_valid = !rst && r_if_rsp_valid;
    assign if_rsp_rdata = sram_dout[DATA_WIDTH-1:0];
    assign if_rsp_perr  = if_rsp_valid && w_dout_perr;
    assign dm_rsp_valid = !rst && r_dm_rsp_valid;
    assign dm_rsp_rdata = sram_dout[DATA_WIDTH-1:0];
    assign dm_rsp_perr  = dm_rsp_valid && (r_dm_rsp_rd ? w_dout_perr : r_dm_rsp_perr);

endmodule
`default_nettype wire

// File: tb/tb_sram_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_sram_port_ctrl
// Brief   : Directed bench for sram_port_ctrl with a behavioural 1rw macro.
// Revision: 1.0
// ============================================================================
module tb_sram_port_ctrl;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          init_done;
    logic          if_req_valid, if_req_ready, if_rsp_valid, if_rsp_perr;
    logic [AW-1:0] if_req_addr;
    logic [DW-1:0] if_rsp_rdata;
    logic          dm_req_valid, dm_req_ready, dm_req_we, dm_rsp_valid, dm_rsp_perr;
    logic [NW-1:0] dm_req_be;
    logic [AW-1:0] dm_req_addr;
    logic [DW-1:0] dm_req_wdata, dm_rsp_rdata;
    logic          sram_csb, sram_web, sram_spare_wen;
    logic [NW-1:0] sram_wmask;
    logic [AW-1:0] sram_addr;
    logic [DW:0]   sram_din;
    logic [DW:0]   sram_dout;

    int vectors     = 0;
    int miscompares = 0;

    logic [3:0] arb_exp [5] = '{4'b0100, 4'b1001, 4'b0110, 4'b1001, 4'b0010};

    always #5 clk = ~clk;

    sram_port_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_WMASKS (NW),
        .INIT_CLEAR (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .init_done      (init_done),
        .if_req_valid   (if_req_valid),
        .if_req_ready   (if_req_ready),
        .if_req_addr    (if_req_addr),
        .if_rsp_valid   (if_rsp_valid),
        .if_rsp_rdata   (if_rsp_rdata),
        .if_rsp_perr    (if_rsp_perr),
        .dm_req_valid   (dm_req_valid),
        .dm_req_ready   (dm_req_ready),
        .dm_req_we      (dm_req_we),
        .dm_req_be      (dm_req_be),
        .dm_req_addr    (dm_req_addr),
        .dm_req_wdata   (dm_req_wdata),
        .dm_rsp_valid   (dm_rsp_valid),
        .dm_rsp_rdata   (dm_rsp_rdata),
        .dm_rsp_perr    (dm_rsp_perr),
        .sram_csb       (sram_csb),
        .sram_web       (sram_web),
        .sram_wmask     (sram_wmask),
        .sram_spare_wen (sram_spare_wen),
        .sram_addr      (sram_addr),
        .sram_din       (sram_din),
        .sram_dout      (sram_dout)
    );

    // Behavioural macro: capture at posedge, read data appears at the next negedge.
    logic [DW:0]   mem [0:(1<<AW)-1];
    logic          rd_pend = 1'b0;
    logic [AW-1:0] rd_addr;
    logic          flip_par = 1'b0;

    always @(posedge clk) begin
        rd_pend <= 1'b0;
        if (!sram_csb) begin
            if (!sram_web) begin
                for (int i = 0; i < NW; i++)
                    if (sram_wmask[i]) mem[sram_addr][8*i +: 8] <= sram_din[8*i +: 8];
                if (sram_spare_wen) mem[sram_addr][DW] <= sram_din[DW];
            end else begin
                rd_pend <= 1'b1;
                rd_addr <= sram_addr;
            end
        end
    end

    always @(negedge clk) begin
        if (rd_pend) sram_dout <= mem[rd_addr] ^ {flip_par, {DW{1'b0}}};
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pk(input logic csb, input logic web, input logic [3:0] wm,
                                       input logic sp, input logic [3:0] a, input logic [32:0] d);
        return {20'h0, csb, web, wm, sp, a, d};
    endfunction

    function automatic logic [63:0] bus();
        return pk(sram_csb, sram_web, sram_wmask, sram_spare_wen, sram_addr, sram_din);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        if_req_valid = 1'b1; if_req_addr = 4'd9;
        dm_req_valid = 1'b1; dm_req_we = 1'b0; dm_req_be = 4'h0;
        dm_req_addr = 4'd0; dm_req_wdata = 32'h0;

        // Reset: requests pending but nothing granted or issued
        cyc(); cyc();
        smp();
        check("rst_outs", {init_done, if_req_ready, dm_req_ready, if_rsp_valid, dm_rsp_valid, sram_csb}, 6'b000001);

        // Zero-fill walk; fetch stays pending to prove it is held off
        cyc(); rst = 1'b0; dm_req_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            smp();
            check("init_wr", bus(), pk(1'b0, 1'b0, 4'hF, 1'b1, i[3:0], 33'h0));
            check("init_busy", {init_done, if_req_ready, dm_req_ready}, 3'b000);
            cyc();
        end
        smp();
        check("init_done_rise", {init_done, if_req_ready, dm_req_ready}, 3'b110);
        check("fetch9_issue", {sram_csb, sram_web, sram_addr}, {2'b01, 4'd9});
        cyc(); if_req_valid = 1'b0;
        smp();
        check("fetch9_rsp", {if_rsp_valid, if_rsp_perr, if_rsp_rdata}, {2'b10, 32'h0});

        // Full write then back-to-back read
        cyc(); dm_req_valid = 1'b1; dm_req_we = 1'b1; dm_req_be = 4'hF;
        dm_req_addr = 4'd5; dm_req_wdata = 32'hDEADBEEF;
        smp();
        check("wr5_ready", {dm_req_ready, if_req_ready}, 2'b10);
        check("wr5_bus", bus(), pk(1'b0, 1'b0, 4'hF, 1'b1, 4'd5, {1'b0, 32'hDEADBEEF}));
        cyc(); dm_req_we = 1'b0;
        smp();
        check("wr5_ack", {dm_rsp_valid, dm_rsp_perr, dm_req_ready, sram_csb, sram_web, sram_addr}, {5'b10101, 4'd5});
        cyc(); dm_req_valid = 1'b0;
        smp();
        check("rd5_rsp", {dm_rsp_valid, dm_rsp_perr, dm_rsp_rdata}, {2'b10, 32'hDEADBEEF});

        // Contention: dm first (reset prio), then alternating
        cyc(); dm_req_valid = 1'b1; dm_req_we = 1'b0; dm_req_addr = 4'd1;
        if_req_valid = 1'b1; if_req_addr = 4'd2;
        for (int k = 0; k < 5; k++) begin
            smp();
            check("arb_seq", {if_req_ready, dm_req_ready, if_rsp_valid, dm_rsp_valid}, arb_exp[k]);
            if (k < 4) check("arb_addr", sram_addr, (k % 2 == 0) ? 4'd1 : 4'd2);
            cyc();
            if (k == 3) begin if_req_valid = 1'b0; dm_req_valid = 1'b0; end
        end

        // Partial write: pre-read, merge, full write; fetch stalls in between
        dm_req_valid = 1'b1; dm_req_we = 1'b1; dm_req_be = 4'hF;
        dm_req_addr = 4'd7; dm_req_wdata = 32'h11223344;
        smp();
        check("wr7_ready", dm_req_ready, 1'b1);
        cyc(); dm_req_be = 4'b0010; dm_req_wdata = 32'h0000AA00;
        if_req_valid = 1'b1; if_req_addr = 4'd7;
        smp();
        check("rmw_rd", {dm_req_ready, if_req_ready, dm_rsp_valid, sram_csb, sram_web, sram_addr}, {5'b10101, 4'd7});
        cyc(); dm_req_valid = 1'b0;
        smp();
        check("rmw_wr", bus(), pk(1'b0, 1'b0, 4'hF, 1'b1, 4'd7, {1'b0, 32'h1122AA44}));
        check("rmw_block", {if_req_ready, dm_req_ready, dm_rsp_valid}, 3'b000);
        cyc();
        smp();
        check("rmw_ack", {dm_rsp_valid, dm_rsp_perr, if_req_ready, sram_csb, sram_addr}, {4'b1010, 4'd7});
        cyc(); if_req_valid = 1'b0;
        smp();
        check("fetch7_rsp", {if_rsp_valid, if_rsp_perr, if_rsp_rdata}, {2'b10, 32'h1122AA44});

        // Second partial write flips the parity bit of the merged word
        cyc(); dm_req_valid = 1'b1; dm_req_be = 4'b0001; dm_req_wdata = 32'hFFFFFF45;
        smp();
        check("rmw2_ready", dm_req_ready, 1'b1);
        cyc(); dm_req_valid = 1'b0;
        smp();
        check("rmw2_wr", bus(), pk(1'b0, 1'b0, 4'hF, 1'b1, 4'd7, {1'b1, 32'h1122AA45}));
        cyc();
        smp();
        check("rmw2_ack", {dm_rsp_valid, dm_rsp_perr}, 2'b10);

        // Byte-enable zero: ack without touching the macro
        cyc(); dm_req_valid = 1'b1; dm_req_be = 4'b0000; dm_req_addr = 4'd3;
        smp();
        check("be0_idle", {dm_req_ready, sram_csb}, 2'b11);

        // Odd-parity word, then fetch with corrupted spare bit
        cyc(); dm_req_be = 4'hF; dm_req_wdata = 32'h00000001;
        smp();
        check("be0_ack", {dm_rsp_valid, dm_rsp_perr}, 2'b10);
        check("wr3_bus", bus(), pk(1'b0, 1'b0, 4'hF, 1'b1, 4'd3, {1'b1, 32'h00000001}));
        cyc(); dm_req_valid = 1'b0; if_req_valid = 1'b1; if_req_addr = 4'd3; flip_par = 1'b1;
        smp();
        check("fetch3_ready", if_req_ready, 1'b1);
        cyc(); if_req_valid = 1'b0;
        smp();
        check("fetch3_perr", {if_rsp_valid, if_rsp_perr, if_rsp_rdata}, {2'b11, 32'h00000001});
        flip_par = 1'b0;

        // Reset while the RMW write is pending
        cyc(); dm_req_valid = 1'b1; dm_req_we = 1'b1; dm_req_be = 4'b0001;
        dm_req_addr = 4'd7; dm_req_wdata = 32'h000000FF;
        smp();
        check("rmw3_ready", dm_req_ready, 1'b1);
        cyc(); dm_req_valid = 1'b0; rst = 1'b1;
        smp();
        check("rst_rmw", {sram_csb, dm_rsp_valid, init_done}, 3'b100);
        cyc(); rst = 1'b0;
        smp();
        check("reinit0", bus(), pk(1'b0, 1'b0, 4'hF, 1'b1, 4'd0, 33'h0));
        check("reinit_noack", {dm_rsp_valid, init_done}, 2'b00);
        cyc();
        smp();
        check("reinit1", bus(), pk(1'b0, 1'b0, 4'hF, 1'b1, 4'd1, 33'h0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_port_ctrl.md
Name: sram_port_ctrl

Overview:
- Controller in front of one 33-bit-wide single-port OpenRAM macro (1rw, byte write mask plus spare bit).
- Shares the macro between an instruction-fetch port (read-only) and a data port (read/write), arbitrated round-robin.
- Uses the spare bit 32 as even parity, with read-modify-write for partial-byte stores.
- Zero-fills the whole array after reset before serving any request.

Parameters:
- ADDR_WIDTH, 10, word address width of the macro.
- DATA_WIDTH, 32, payload width; macro word is DATA_WIDTH+1.
- NUM_WMASKS, 4, byte lanes (DATA_WIDTH/8).
- INIT_CLEAR, 1, if 1 zero-fill all 2^ADDR_WIDTH words after reset; if 0 go directly to RUN.

Ports:
- clk  in  1  single clock; also drives the macro clk0.
- rst  in  1  synchronous, active-high reset.
- init_done  out  1  high once RUN is reached.
- if_req_valid  in  1  fetch request.
- if_req_ready  out  1  fetch accepted this cycle.
- if_req_addr  in  ADDR_WIDTH  word address.
- if_rsp_valid  out  1  fetch data valid (1-cycle pulse).
- if_rsp_rdata  out  DATA_WIDTH  fetch data.
- if_rsp_perr  out  1  parity error on this fetch.
- dm_req_valid  in  1  data request.
- dm_req_ready  out  1  data request accepted.
- dm_req_we  in  1  1 = write.
- dm_req_be  in  NUM_WMASKS  byte enables for writes.
- dm_req_addr  in  ADDR_WIDTH  word address.
- dm_req_wdata  in  DATA_WIDTH  write data.
- dm_rsp_valid  out  1  read data or write ack (pulse).
- dm_rsp_rdata  out  DATA_WIDTH  read data; undefined on write ack.
- dm_rsp_perr  out  1  parity error (read, or RMW pre-read).
- sram_csb  out  1  macro csb0.
- sram_web  out  1  macro web0.
- sram_wmask  out  NUM_WMASKS  macro wmask0.
- sram_spare_wen  out  1  macro spare_wen0.
- sram_addr  out  ADDR_WIDTH  macro addr0.
- sram_din  out  DATA_WIDTH+1  macro din0; bit 32 is parity.
- sram_dout  in  DATA_WIDTH+1  macro dout0.

Behaviour:
- Macro timing: inputs are captured at the posedge that ends cycle N. dout updates at the negedge in cycle N+1 and is sampled at the posedge ending N+1.
- All sram_* outputs are combinational from state plus the granted request. sram_csb=1 whenever no access is issued.
- Read latency is fixed at 1: a request accepted in cycle N gives rsp_valid in N+1, with rdata = sram_dout[31:0].
- Back-to-back requests are allowed. There is no response backpressure.
- Requester rule: request fields stay stable while valid && !ready.
- Parity: sram_din[32] = ^sram_din[31:0]. perr = ^sram_dout[32:0] on read responses.
- States:
  - INIT: ready=0. Counter walks addresses 0..2^ADDR_WIDTH-1, one full write per cycle, data 0, wmask all ones, spare_wen=1. After the last address go to RUN.
  - RUN: grant at most one port per cycle.
    - One valid port: grant it.
    - Both valid: grant the port named by the prio bit, then flip prio to the other port. prio resets to data.
    - Fetch, or data read: web=1, response in the next cycle.
    - Data write with be all ones: web=0, wmask=1111, spare_wen=1; ack next cycle.
    - Data write with be=0: accepted, macro idle, ack next cycle, perr=0.
    - Other be values: issue a read (web=1) at the address, latch addr/be/wdata, go to RMW_WR.
  - RMW_WR: both ready=0. Merge selected bytes of wdata into sram_dout[31:0], recompute parity, write the full word (wmask=1111, spare_wen=1).
    - dm ack is given next cycle.
    - perr = parity check of the pre-read word; the write proceeds regardless.
    - Return to RUN. prio is unchanged.
- A partial write therefore occupies the macro for 2 cycles and its ack arrives 2 cycles after accept.
- Reset values: init_done=0, both rsp_valid=0, both ready=0, sram_csb=1, prio=data, INIT counter=0.
- State after reset: INIT (INIT_CLEAR=1) or RUN (INIT_CLEAR=0).
- Reset mid-operation: a pending RMW or response is dropped, and INIT restarts from address 0.
- A read at address A right after an ack for A returns the new data; no forwarding is needed because of single-port ordering.

Decomposition:
- Shared package sram_ctrl_pkg:
  - state enum {INIT, RUN, RMW_WR};
  - port-id constants PORT_IF, PORT_DM;
  - parity function.
- One natural sub-module, sram_rr_arbiter: 2-input round-robin with prio flip-flop; inputs valid/enable, outputs grant one-hot.
- Everything else stays in the top.

Test Plan:
- Reset, INIT_CLEAR=1, ADDR_WIDTH=4:
  - init_done rises exactly 16 cycles after rst falls;
  - 16 writes of 33'h0 to addresses 0..15;
  - a subsequent fetch of any address returns 0 with perr=0.
- dm write 0xDEADBEEF, be=1111 @5, then dm read @5:
  - din = {1'b0(parity of DEADBEEF = 24 ones -> 0), DEADBEEF};
  - read rsp next cycle = DEADBEEF, perr=0.
- Both ports valid every cycle to addrs 1/2:
  - grants alternate dm, if, dm, if;
  - each rsp_valid exactly 1 cycle after its ready.
- Word 0x11223344 @7, dm write be=0010 wdata 0x0000AA00:
  - 2 macro cycles (read, then full write 0x1122AA44 with correct parity);
  - fetch blocked in RMW_WR; ack 2 cycles after accept.
- Force sram_dout bit 32 flipped on a read of @3 -> if_rsp_perr=1 with data unchanged.
- Assert rst during RMW_WR -> no ack issued, sram_csb=1 during the reset cycle, INIT restarts at address 0.
